// File: rtl/dd_puf_reader_if.sv
// Host-side byte interface of the dual-latch PUF reader.
// The host (master) requests a readout and accepts response bytes over a
// valid/ready handshake; the reader (slave) reports BUSY/DONE and drives bytes.
interface dd_puf_reader_if;
  logic       req;
  logic       busy;
  logic       done;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (
    output req,
    output dout_ready,
    input  busy,
    input  done,
    input  dout,
    input  dout_valid
  );

  modport slave (
    input  req,
    input  dout_ready,
    output busy,
    output done,
    output dout,
    output dout_valid
  );
endinterface

// File: rtl/dd_puf_reader.sv
// Sequencer and readout engine for the 128-instance dual-latch PUF array.
// A request clears the array, lets it settle with START high, captures the
// synchronised 128-bit response and streams it out as 16 bytes, LSB byte first.
//
// Optional feature macro: DD_PUF_MAJORITY_EN
//   defined   : three evaluations per request, the streamed response is the
//               bitwise majority of the three captures.
//   undefined : a single evaluation, the capture is streamed directly.
module dd_puf_reader #(
  parameter int RESET_CYCLES  = 4,   // cycles PUF_RESET is held before evaluation (>= 1)
  parameter int SETTLE_CYCLES = 16   // cycles PUF_START is held before capture (>= 3)
) (
  input  logic           clk,
  input  logic           rst,
  dd_puf_reader_if.slave host,
  output logic           puf_reset_o,
  output logic           puf_start_o,
  input  logic [127:0]   puf_resp_i
);

  // Cycle counter covers the longer of the two timed phases.
  localparam int MAX_CYC = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] CLEAR_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [3:0]    LAST_BYTE   = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_EVAL    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SEND    = 3'd4
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [3:0]     byte_idx_q;
  logic [127:0]   resp_q;
  logic [127:0]   sync1_q;
  logic [127:0]   sync2_q;

  // Registered outputs
  logic           busy_q;
  logic           done_q;
  logic           puf_reset_q;
  logic           puf_start_q;
  logic [7:0]     dout_q;
  logic           dout_valid_q;

  // Value loaded into the output register on the final capture
  logic [127:0]   capture_d;
  logic [3:0]     next_idx_d;
  logic [7:0]     resp_bytes [16];

`ifdef DD_PUF_MAJORITY_EN
  logic [1:0]     eval_idx_q;
  logic [127:0]   e0_q;
  logic [127:0]   e1_q;
`endif

  // The response pins are asynchronous to clk: two-flop synchroniser, free-running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= puf_resp_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef DD_PUF_MAJORITY_EN
  // Bitwise 2-of-3 vote of the two stored evaluations and the live one.
  assign capture_d = (e0_q & e1_q) | (e1_q & sync2_q) | (e0_q & sync2_q);
`else
  assign capture_d = sync2_q;
`endif

  // Byte n of the captured response is bits 8n+7:8n.
  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    assign resp_bytes[gi] = resp_q[8*gi +: 8];
  end

  assign next_idx_d = byte_idx_q + 4'd1;

  // Sequencer: phase timing, capture, byte streaming and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      byte_idx_q   <= '0;
      resp_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      puf_reset_q  <= 1'b1;
      puf_start_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef DD_PUF_MAJORITY_EN
      eval_idx_q   <= '0;
      e0_q         <= '0;
      e1_q         <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (host.req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
`ifdef DD_PUF_MAJORITY_EN
            eval_idx_q <= '0;
`endif
          end
        end

        ST_CLEAR: begin
          if (cnt_q == CLEAR_LAST) begin
            state_q     <= ST_EVAL;
            cnt_q       <= '0;
            puf_reset_q <= 1'b0;
            puf_start_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_EVAL: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= ST_CAPTURE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_CAPTURE: begin
          // START/RESET flip back to the reset pattern in either branch.
          puf_reset_q <= 1'b1;
          puf_start_q <= 1'b0;
`ifdef DD_PUF_MAJORITY_EN
          if (eval_idx_q != 2'd2) begin
            if (eval_idx_q == 2'd0) begin
              e0_q <= sync2_q;
            end else begin
              e1_q <= sync2_q;
            end
            eval_idx_q <= eval_idx_q + 2'd1;
            state_q    <= ST_CLEAR;
          end else begin
            resp_q       <= capture_d;
            dout_q       <= capture_d[7:0];
            dout_valid_q <= 1'b1;
            byte_idx_q   <= '0;
            state_q      <= ST_SEND;
          end
`else
          resp_q       <= capture_d;
          dout_q       <= capture_d[7:0];
          dout_valid_q <= 1'b1;
          byte_idx_q   <= '0;
          state_q      <= ST_SEND;
`endif
        end

        ST_SEND: begin
          // A byte moves only on valid & ready; otherwise dout_q holds.
          if (dout_valid_q && host.dout_ready) begin
            if (byte_idx_q == LAST_BYTE) begin
              dout_valid_q <= 1'b0;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= ST_IDLE;
            end else begin
              byte_idx_q <= next_idx_d;
              dout_q     <= resp_bytes[next_idx_d];
            end
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          puf_reset_q  <= 1'b1;
          puf_start_q  <= 1'b0;
          dout_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign host.busy       = busy_q;
  assign host.done       = done_q;
  assign host.dout       = dout_q;
  assign host.dout_valid = dout_valid_q;
  assign puf_reset_o     = puf_reset_q;
  assign puf_start_o     = puf_start_q;

endmodule

// File: tb/tb_dd_puf_reader.sv
// Self-checking bench for dd_puf_reader. Randomised responses and ready
// patterns are compared against a behavioural model of the readout: the
// expected stream is the (voted) response split into bytes, with phase
// lengths computed from the cycle parameters.
module tb_dd_puf_reader;

  localparam int R = 4;
  localparam int S = 16;
  localparam int L = R + S + 1;   // cycles per evaluation round
`ifdef DD_PUF_MAJORITY_EN
  localparam int NR = 3;
`else
  localparam int NR = 1;
`endif

  logic         clk;
  logic         rst;
  logic         puf_reset_w;
  logic         puf_start_w;
  logic [127:0] puf_resp;

  int errors;
  int checks;

  dd_puf_reader_if bus ();

  dd_puf_reader #(
    .RESET_CYCLES (R),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (bus),
    .puf_reset_o(puf_reset_w),
    .puf_start_o(puf_start_w),
    .puf_resp_i (puf_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Response the host should receive for the given evaluation values.
  function automatic logic [127:0] model_resp(input logic [127:0] a, b, c);
    logic [127:0] res;
    res = a;
`ifdef DD_PUF_MAJORITY_EN
    for (int i = 0; i < 128; i++) begin
      res[i] = ((a[i] + b[i] + c[i]) >= 2);
    end
`endif
    return res;
  endfunction

  // One complete readout. Cycle 1 is the cycle right after the edge that
  // samples REQ; v0..v2 are the pin values presented for rounds 0..2.
  task automatic run_readout(input string name, input logic [127:0] v0, v1, v2,
                             input bit noise, input int ready_pct,
                             input bit req_in_send, input bit chain, input bit started);
    logic [127:0] vals [3];
    logic [127:0] exp_resp;
    logic [7:0]   got [$];
    logic [7:0]   prev_dout;
    int t, first_valid, start_cnt, overlap, done_t, r, o;
    bit finished, prev_stall, xfer;

    vals[0] = v0; vals[1] = v1; vals[2] = v2;
    exp_resp = model_resp(v0, v1, v2);
    first_valid = -1; start_cnt = 0; overlap = 0; done_t = -1;
    finished = 0; prev_stall = 0; prev_dout = '0;

    if (!started) begin
      puf_resp = v0;
      bus.req = 1'b1;
      tick();
      bus.req = 1'b0;
    end
    t = 1;

    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_req: got %b want 1", name, bus.busy);
    end

    while (!finished && t < 1000) begin
      r = (t - 1) / L;
      if (r > NR - 1) r = NR - 1;
      o = t - r * L;
      puf_resp = (noise && o < R + S - 2) ? rand128() : vals[r];

      if (prev_stall) begin
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== prev_dout) begin
          errors++;
          $display("FAIL %s stall_hold t=%0d: got valid=%b dout=%h want valid=1 dout=%h",
                   name, t, bus.dout_valid, bus.dout, prev_dout);
        end
      end
      if (bus.dout_valid === 1'b1 && first_valid < 0) first_valid = t;
      if (puf_start_w === 1'b1) start_cnt++;
      if (puf_start_w === puf_reset_w) overlap++;

      bus.req = 1'b0;
      if (bus.done === 1'b1) begin
        done_t = t;
        finished = 1;
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_during_done: got %b want 0", name, bus.busy);
        end
        if (chain) bus.req = 1'b1;
      end

      bus.dout_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      xfer = (bus.dout_valid === 1'b1) && bus.dout_ready;
      if (req_in_send && bus.dout_valid === 1'b1 &&
          (got.size() == 4 || (xfer && got.size() == 15))) bus.req = 1'b1;
      if (xfer) got.push_back(bus.dout);
      prev_stall = (bus.dout_valid === 1'b1) && !bus.dout_ready;
      prev_dout = bus.dout;

      tick();
      t++;
    end
    bus.req = 1'b0;
    bus.dout_ready = 1'b0;

    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: got no DONE within %0d cycles want DONE", name, t);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse_width: got %b want 0", name, bus.done);
    end
    checks++;
    if (bus.busy !== chain) begin
      errors++;
      $display("FAIL %s busy_after_done: got %b want %b", name, bus.busy, chain);
    end
    checks++;
    if (first_valid != NR * L + 1) begin
      errors++;
      $display("FAIL %s first_valid_cycle: got %0d want %0d", name, first_valid, NR * L + 1);
    end
    checks++;
    if (start_cnt != NR * (S + 1)) begin
      errors++;
      $display("FAIL %s start_high_cycles: got %0d want %0d", name, start_cnt, NR * (S + 1));
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL %s start_reset_exclusive: got %0d bad cycles want 0", name, overlap);
    end
    if (ready_pct >= 100) begin
      checks++;
      if (done_t != NR * L + 17) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d want %0d", name, done_t, NR * L + 17);
      end
    end
    checks++;
    if (got.size() != 16) begin
      errors++;
      $display("FAIL %s byte_count: got %0d want 16", name, got.size());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp_resp[8*i +: 8]) begin
        errors++;
        $display("FAIL %s byte%0d: got %h want %h", name, i,
                 (i < got.size()) ? got[i] : 8'hxx, exp_resp[8*i +: 8]);
      end
    end
    $display("%s: %0d bytes, first valid cycle %0d, done cycle %0d, resp %h",
             name, got.size(), first_valid, done_t, exp_resp);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (puf_reset_w !== 1'b1 || puf_start_w !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.dout_valid !== 1'b0 || bus.dout !== 8'h00) begin
      errors++;
      $display("FAIL %s reset_outputs: got rst=%b start=%b busy=%b done=%b valid=%b dout=%h want 1 0 0 0 0 00",
               name, puf_reset_w, puf_start_w, bus.busy, bus.done, bus.dout_valid, bus.dout);
    end
  endtask

  task automatic test_reset();
    logic [127:0] v;
    rst = 1'b1;
    tick();
    tick();
    check_idle_outputs("power_on");
    rst = 1'b0;
    tick();

    v = rand128();
    puf_resp = v;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    repeat (R + 2) tick();
    checks++;
    if (puf_start_w !== 1'b1) begin
      errors++;
      $display("FAIL mid_eval start_before_reset: got %b want 1", puf_start_w);
    end
    #1 rst = 1'b1;
    #1;
    check_idle_outputs("mid_eval_reset");
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_eval idle_after_release: got busy=%b want 0", bus.busy);
    end
    $display("test_reset: reset applied mid-EVAL");
    run_readout("after_reset", v, v, v, 0, 100, 0, 0, 0);
  endtask

  task automatic test_single();
    logic [127:0] v;
    v = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    run_readout("spec_vector", v, v, v, 0, 100, 0, 0, 0);
    for (int n = 0; n < 2; n++) begin
      v = rand128();
      run_readout("random_single", v, rand128(), rand128(), 0, 100, 0, 0, 0);
    end
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 2; n++) begin
      logic [127:0] v;
      v = rand128();
      run_readout("backpressure", v, v, v, 0, 50, 0, 0, 0);
    end
  endtask

  task automatic test_req_during_send();
    logic [127:0] v;
    v = rand128();
    run_readout("req_in_send", v, v, v, 0, 100, 1, 0, 0);
    v = rand128();
    run_readout("req_in_send_bp", v, v, v, 0, 60, 1, 0, 0);
  endtask

  task automatic test_changing_resp();
    logic [127:0] a, b, c;
    a = rand128(); b = rand128(); c = rand128();
    run_readout("changing_resp", a, b, c, 1, 100, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b;
    a = rand128(); b = rand128();
    run_readout("chain_first", a, a, a, 0, 100, 0, 1, 0);
    run_readout("chain_second", b, b, b, 0, 70, 0, 0, 1);
  endtask

  task automatic test_majority();
    run_readout("majority_101", {128{1'b1}}, 128'h0, {128{1'b1}}, 0, 100, 0, 0, 0);
    run_readout("majority_rand", rand128(), rand128(), rand128(), 1, 80, 0, 0, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.req = 1'b0;
    bus.dout_ready = 1'b0;
    puf_resp = '0;

    test_reset();
    test_single();
    test_backpressure();
    test_req_during_send();
    test_changing_resp();
    test_back_to_back();
    test_majority();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dd_puf_reader.md
# dd_puf_reader

Sequencer and readout engine for the 128-instance dual-latch PUF array. On request it clears the array, enables evaluation for a fixed settle window, synchronises and captures the 128-bit response, and streams it out as sixteen bytes over a valid/ready handshake. It sits between the PUF array's START/RESET/RESPONSE pins and the host-side byte interface.

## Interface
- RESET_CYCLES, 4, cycles PUF_RESET is held high before evaluation (min 1)
- SETTLE_CYCLES, 16, cycles PUF_START is held high before capture (min 3, covers synchroniser)
- CLK  input  1  system clock, all state on rising edge
- RESET  input  1  one clock; reset is asynchronous and active-high
- REQ  input  1  start one readout; sampled only in IDLE
- BUSY  output  1  high whenever state ≠ IDLE
- DONE  output  1  one-cycle pulse after final byte accepted
- PUF_RESET  output  1  drives array RESET
- PUF_START  output  1  drives array START
- PUF_RESP  input  128  array RESPONSE, asynchronous to CLK
- DOUT  output  8  response byte
- DOUT_VALID  output  1  DOUT holds a valid byte
- DOUT_READY  input  1  consumer accepts byte

## Operation
- PUF_RESP passes through a 2-flop synchroniser (all 128 bits, free-running, reset to 0).
- States: IDLE, CLEAR, EVAL, CAPTURE, SEND.
- IDLE: PUF_RESET=1, PUF_START=0. REQ=1 → CLEAR, eval index cleared to 0.
- CLEAR: PUF_RESET=1, PUF_START=0 for exactly RESET_CYCLES cycles → EVAL.
- EVAL: PUF_RESET=0, PUF_START=1 for exactly SETTLE_CYCLES cycles → CAPTURE.
- CAPTURE (1 cycle): PUF_RESET=0, PUF_START=1; synchroniser output loaded into eval register; → SEND (single mode) or per Configuration.
- SEND: PUF_RESET=1, PUF_START=0; byte index 0..15, byte n = resp[8n+7:8n] (byte 0 = bits 7:0).
- Handshake: byte transfers on DOUT_VALID & DOUT_READY at a rising edge; DOUT stable while VALID & !READY; VALID not dropped until transfer; back-to-back transfers allowed (one byte per cycle with READY held high).
- Byte 15 transfer → DONE=1 next cycle, state IDLE, DOUT_VALID=0.
- REQ while BUSY ignored; not queued.
- Counters sized $clog2(max(RESET_CYCLES,SETTLE_CYCLES)+1); byte index 4 bits, no wrap past 15.

## Timing
- Reset values: BUSY=0, DONE=0, PUF_RESET=1, PUF_START=0, DOUT=0, DOUT_VALID=0; state IDLE; capture regs 0.
- RESET assertion mid-operation: all outputs to reset values immediately (asynchronous), any partial transfer discarded.
- REQ sampled high at edge k: BUSY=1 and CLEAR from k+1; EVAL from k+1+R; CAPTURE at k+1+R+S; DOUT_VALID=1 from k+R+S+2 (R=RESET_CYCLES, S=SETTLE_CYCLES).
- With READY held high: last byte accepted at edge k+R+S+17; DONE high for cycle after it; BUSY low same cycle as DONE.
- REQ high on the same edge that DONE is asserted: ignored (state was SEND); REQ during DONE cycle starts new readout.

## Configuration
- DD_PUF_MAJORITY_EN defined: three evaluations (CLEAR→EVAL→CAPTURE repeated, eval index 0,1,2); captures 0 and 1 stored in E0, E1; on third CAPTURE the output register loads bitwise majority (E0&E1)|(E1&s)|(E0&s) where s is the synchroniser output; → SEND. First DOUT_VALID at k+3(R+S+1)+1.
- Not defined: single evaluation, E0/E1 absent, output register loads s directly.

## Test plan
- Reset: assert RESET mid-EVAL → PUF_RESET=1, PUF_START=0, BUSY=0, DOUT_VALID=0 immediately; REQ afterwards runs full sequence.
- Single readout, R=4, S=16, PUF_RESP=128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, READY=1 → PUF_START high exactly 17 cycles, DOUT_VALID at k+22, bytes F0,E1,D2,C3,...,0F, DONE one cycle.
- Backpressure: READY toggled 1-0-0-1 random → every byte delivered once, in order, DOUT stable while stalled.
- REQ pulsed during SEND → no restart; byte count stays 16; single DONE.
- PUF_RESP changing during CLEAR and EVAL, stable for last 3 EVAL cycles → captured value equals stable value.
- With DD_PUF_MAJORITY_EN: PUF_RESP = all-ones for evals 0,2 and all-zeros for eval 1 → all 16 bytes 0xFF; first DOUT_VALID at k+64.
